// File: rtl/qupls4_rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg / Qupls4_pkg
//  Description : Shared CPU types and Qupls4 constants used by the register
//                file write arbiter and its requester queues.
//  Revision    : 1.0  initial release
// ============================================================================

package cpu_types_pkg;
    typedef logic [63:0] value_t;
    typedef logic [8:0]  pregno_t;
    typedef logic [63:0] pc_address_t;
endpackage

package Qupls4_pkg;
    localparam int PREGS     = 512;
    // Number of register file write ports driven by the write arbiter.
    localparam int RF_WPORTS = 4;

    typedef logic [7:0] flags_t;

    // Saturating 16-bit increment for event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

`default_nettype wire

// File: rtl/qupls4_rf_wrq.sv
`default_nettype none
// ============================================================================
//  Module      : qupls4_rf_wrq
//  Description : Small FDEP-entry FIFO holding pending register-file results
//                for one requester; exposes the head entry and fill count.
//  Revision    : 1.0  initial release
// ============================================================================

module qupls4_rf_wrq #(
    parameter int FDEP = 2,
    parameter int DW   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DW-1:0]             din,
    output logic [DW-1:0]             dout,
    output logic [$clog2(FDEP):0]     count,
    output logic                      empty
);
    localparam int AW = $clog2(FDEP);
    localparam int CW = AW + 1;

    logic [DW-1:0] r_mem [FDEP];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;

    // Storage array is not reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers wrap naturally because FDEP is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_cnt;
    assign empty = (r_cnt == '0);
endmodule

`default_nettype wire

// File: rtl/qupls4_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qupls4_rf_write_arbiter
//  Description : Queues results from NREQ functional units and writes up to
//                RF_WPORTS of them per cycle into the register file, scanning
//                queue heads round-robin and never writing one preg twice in
//                a cycle.
//  Revision    : 1.0  initial release
// ============================================================================

module qupls4_rf_write_arbiter
    import cpu_types_pkg::*;
    import Qupls4_pkg::*;
#(
    parameter int NREQ = 6,
    parameter int WID  = $bits(value_t) + $bits(flags_t),
    parameter int BWW  = 8,
    parameter int FDEP = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_v,
    output logic [NREQ-1:0]      req_rdy,
    input  pregno_t              req_pr  [NREQ],
    input  value_t               req_val [NREQ],
    input  flags_t               req_flg [NREQ],
    input  logic [WID/BWW:0]     req_we  [NREQ],
    output logic                 wr0,
    output logic                 wr1,
    output logic                 wr2,
    output logic                 wr3,
    output logic [WID/BWW:0]     we0,
    output logic [WID/BWW:0]     we1,
    output logic [WID/BWW:0]     we2,
    output logic [WID/BWW:0]     we3,
    output pregno_t              wa0,
    output pregno_t              wa1,
    output pregno_t              wa2,
    output pregno_t              wa3,
    output value_t               i0,
    output value_t               i1,
    output value_t               i2,
    output value_t               i3,
    output flags_t               ti0,
    output flags_t               ti1,
    output flags_t               ti2,
    output flags_t               ti3,
    output logic [15:0]          congest_cnt
);
    localparam int BEW = WID / BWW + 1;
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(FDEP) + 1;
    localparam int VB  = $bits(value_t);
    localparam int FB  = $bits(flags_t);
    localparam int PB  = $bits(pregno_t);
    localparam int DW  = BEW + PB + FB + VB;
    localparam int NP  = RF_WPORTS;

    logic [NREQ-1:0]  w_push;
    logic [NREQ-1:0]  w_pop;
    logic [NREQ-1:0]  w_empty;
    logic [CW-1:0]    w_cnt     [NREQ];
    logic [CW-1:0]    w_cnt_nxt [NREQ];
    logic [DW-1:0]    w_head    [NREQ];
    pregno_t          w_h_pr    [NREQ];
    value_t           w_h_val   [NREQ];
    flags_t           w_h_flg   [NREQ];
    logic [BEW-1:0]   w_h_we    [NREQ];

    logic [NREQ-1:0]  r_rdy;
    logic [RRW-1:0]   r_rr;
    logic [15:0]      r_cong;
    logic [NP-1:0]    r_wr;
    pregno_t          r_wa [NP];
    value_t           r_i  [NP];
    flags_t           r_ti [NP];
    logic [BEW-1:0]   r_we [NP];

    logic [NP-1:0]    w_port_v;
    logic [RRW-1:0]   w_port_q  [NP];
    pregno_t          w_port_pr [NP];
    logic [RRW-1:0]   w_rr_nxt;
    logic [RRW:0]     w_sum;
    logic [RRW-1:0]   w_idx;
    logic             w_dup;
    logic             w_placed;
    logic             w_congested;

    generate
        for (genvar n = 0; n < NREQ; n++) begin : g_q
            // Reset blocks pushes so a result in flight is simply dropped.
            assign w_push[n]    = req_v[n] & r_rdy[n] & rst_n;
            assign w_cnt_nxt[n] = w_cnt[n] + CW'(w_push[n]) - CW'(w_pop[n]);

            qupls4_rf_wrq #(
                .FDEP (FDEP),
                .DW   (DW)
            ) u_wrq (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (w_push[n]),
                .pop   (w_pop[n]),
                .din   ({req_we[n], req_pr[n], req_flg[n], req_val[n]}),
                .dout  (w_head[n]),
                .count (w_cnt[n]),
                .empty (w_empty[n])
            );

            assign w_h_val[n] = w_head[n][0 +: VB];
            assign w_h_flg[n] = w_head[n][VB +: FB];
            assign w_h_pr[n]  = w_head[n][VB+FB +: PB];
            assign w_h_we[n]  = w_head[n][VB+FB+PB +: BEW];
        end
    endgenerate

    assign w_congested = ($countones(~w_empty) > NP);

    // Round-robin head scan: preg-0 heads are discarded, duplicate pregs wait.
    always_comb begin
        w_pop    = '0;
        w_port_v = '0;
        w_rr_nxt = r_rr;
        w_sum    = '0;
        w_idx    = '0;
        w_dup    = 1'b0;
        w_placed = 1'b0;
        for (int k = 0; k < NP; k++) begin
            w_port_q[k]  = '0;
            w_port_pr[k] = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_rr} + (RRW+1)'(i);
            w_idx = (w_sum >= (RRW+1)'(NREQ)) ? RRW'(w_sum - (RRW+1)'(NREQ)) : RRW'(w_sum);
            w_dup = 1'b0;
            for (int k = 0; k < NP; k++)
                if (w_port_v[k] && (w_port_pr[k] == w_h_pr[w_idx]))
                    w_dup = 1'b1;
            w_placed = 1'b0;
            if (!w_empty[w_idx]) begin
                if (w_h_pr[w_idx] == '0) begin
                    w_pop[w_idx] = 1'b1;
                end else if (!w_dup) begin
                    for (int k = 0; k < NP; k++) begin
                        if (!w_placed && !w_port_v[k]) begin
                            w_port_v[k]  = 1'b1;
                            w_port_q[k]  = w_idx;
                            w_port_pr[k] = w_h_pr[w_idx];
                            w_placed     = 1'b1;
                        end
                    end
                    if (w_placed) begin
                        w_pop[w_idx] = 1'b1;
                        w_rr_nxt     = (w_idx == RRW'(NREQ-1)) ? '0 : w_idx + RRW'(1);
                    end
                end
            end
        end
    end

    // Register write ports, ready flags, rr pointer and congestion counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr   <= '0;
            r_rdy  <= '1;
            r_cong <= '0;
            r_wr   <= '0;
            for (int k = 0; k < NP; k++) begin
                r_wa[k] <= '0;
                r_i[k]  <= '0;
                r_ti[k] <= '0;
                r_we[k] <= '0;
            end
        end else begin
            r_rr <= w_rr_nxt;
            r_wr <= w_port_v;
            for (int k = 0; k < NP; k++) begin
                r_wa[k] <= w_port_v[k] ? w_h_pr[w_port_q[k]]  : '0;
                r_i[k]  <= w_port_v[k] ? w_h_val[w_port_q[k]] : '0;
                r_ti[k] <= w_port_v[k] ? w_h_flg[w_port_q[k]] : '0;
                r_we[k] <= w_port_v[k] ? w_h_we[w_port_q[k]]  : '0;
            end
            for (int n = 0; n < NREQ; n++)
                r_rdy[n] <= (w_cnt_nxt[n] < CW'(FDEP));
            if (w_congested)
                r_cong <= sat_inc16(r_cong);
        end
    end

    assign req_rdy     = r_rdy;
    assign congest_cnt = r_cong;
    assign wr0 = r_wr[0];
    assign wr1 = r_wr[1];
    assign wr2 = r_wr[2];
    assign wr3 = r_wr[3];
    assign wa0 = r_wa[0];
    assign wa1 = r_wa[1];
    assign wa2 = r_wa[2];
    assign wa3 = r_wa[3];
    assign i0  = r_i[0];
    assign i1  = r_i[1];
    assign i2  = r_i[2];
    assign i3  = r_i[3];
    assign ti0 = r_ti[0];
    assign ti1 = r_ti[1];
    assign ti2 = r_ti[2];
    assign ti3 = r_ti[3];
    assign we0 = r_we[0];
    assign we1 = r_we[1];
    assign we2 = r_we[2];
    assign we3 = r_we[3];
endmodule

`default_nettype wire
